sump_cmd_decoder: RTL

- Sits directly downstream of the SPI slave.
- Consumes the 40-bit `cmd` word and `execute` strobe, then decodes SUMP short and long commands.
- Holds the capture configuration registers (divider, read/delay counts, flags) and forwards trigger-stage writes as one-cycle pulses.
- Drives control handshakes to the sampler core: soft reset, arm request/acknowledge, and XON/XOFF flow state.

---
 rtl/sump_cmd_pkg.sv | 35 +++
 rtl/sump_cmd_decoder.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/sump_cmd_pkg.sv
// -----------------------------------------------------------------------------
// sump_cmd_pkg
// Shared SUMP protocol constants: command opcodes, trigger write kinds and a
// helper to recognise the trigger opcode block. Imported by the command
// decoder and by the SPI slave's special-command handling.
// -----------------------------------------------------------------------------
package sump_cmd_pkg;

  // Short (single byte) commands
  localparam logic [7:0] OP_RESET       = 8'h00;
  localparam logic [7:0] OP_ARM         = 8'h01;
  localparam logic [7:0] OP_QUERY_ID    = 8'h02;
  localparam logic [7:0] OP_QUERY_META  = 8'h04;
  localparam logic [7:0] OP_QUERY_INPUT = 8'h06;
  localparam logic [7:0] OP_XON         = 8'h11;
  localparam logic [7:0] OP_XOFF        = 8'h13;

  // Long (opcode + 32-bit operand) commands
  localparam logic [7:0] OP_DIVIDER     = 8'h80;
  localparam logic [7:0] OP_COUNTS      = 8'h81;
  localparam logic [7:0] OP_FLAGS       = 8'h82;

  // Trigger block occupies 0xC0-0xCF: [3:2] stage, [1:0] kind
  localparam logic [7:0] OP_TRIG_BASE   = 8'hC0;

  localparam logic [1:0] TRIG_KIND_MASK   = 2'd0;
  localparam logic [1:0] TRIG_KIND_VALUE  = 2'd1;
  localparam logic [1:0] TRIG_KIND_CONFIG = 2'd2;

  // True when the opcode falls inside the 16-entry trigger block.
  function automatic logic is_trig_op(input logic [7:0] op);
    return (op[7:4] == OP_TRIG_BASE[7:4]);
  endfunction

endpackage : sump_cmd_pkg

// File: rtl/sump_cmd_decoder.sv
// -----------------------------------------------------------------------------
// sump_cmd_decoder
// Decodes SUMP short/long commands delivered by the SPI slave and holds the
// capture configuration registers for the sampler core.
//
// Ports:
//   clock          in   sole clock, rising edge
//   extReset_n     in   asynchronous active-low reset
//   cmd[39:0]      in   [7:0] opcode, [39:8] operand
//   execute        in   level; its rising edge marks a new command
//   arm_ack        in   sampler accepted the arm request
//   soft_reset     out  one-cycle pulse on opcode 0x00
//   arm_req        out  level, held until arm_ack
//   xoff           out  transmit-pause level
//   divider        out  sample clock divider
//   read_count     out  samples to read
//   delay_count    out  post-trigger delay
//   flags          out  capture flags
//   trig_wr_*      out  one-cycle trigger write pulses (mask/value/config)
//   trig_stage     out  stage index of the last trigger write
//   trig_data      out  operand of the last trigger write
//   bad_cmd_count  out  saturating count of unrecognised opcodes
// Every output is driven directly from a flop.
// -----------------------------------------------------------------------------
module sump_cmd_decoder
  import sump_cmd_pkg::*;
#(
  parameter int BAD_CNT_W = 8
) (
  input  logic                 clock,
  input  logic                 extReset_n,
  input  logic [39:0]          cmd,
  input  logic                 execute,
  input  logic                 arm_ack,
  output logic                 soft_reset,
  output logic                 arm_req,
  output logic                 xoff,
  output logic [23:0]          divider,
  output logic [15:0]          read_count,
  output logic [15:0]          delay_count,
  output logic [15:0]          flags,
  output logic                 trig_wr_mask,
  output logic                 trig_wr_value,
  output logic                 trig_wr_config,
  output logic [1:0]           trig_stage,
  output logic [31:0]          trig_data,
  output logic [BAD_CNT_W-1:0] bad_cmd_count
);

  localparam logic [BAD_CNT_W-1:0] BAD_MAX = {BAD_CNT_W{1'b1}};
  localparam logic [BAD_CNT_W-1:0] BAD_ONE = {{(BAD_CNT_W-1){1'b0}}, 1'b1};

  logic                 exec_q;
  logic                 soft_reset_q,     soft_reset_d;
  logic                 arm_req_q,        arm_req_d;
  logic                 xoff_q,           xoff_d;
  logic [23:0]          divider_q,        divider_d;
  logic [15:0]          read_count_q,     read_count_d;
  logic [15:0]          delay_count_q,    delay_count_d;
  logic [15:0]          flags_q,          flags_d;
  logic                 trig_wr_mask_q,   trig_wr_mask_d;
  logic                 trig_wr_value_q,  trig_wr_value_d;
  logic                 trig_wr_config_q, trig_wr_config_d;
  logic [1:0]           trig_stage_q,     trig_stage_d;
  logic [31:0]          trig_data_q,      trig_data_d;
  logic [BAD_CNT_W-1:0] bad_cnt_q,        bad_cnt_d;

  logic        accept_s;
  logic [7:0]  op_s;
  logic [31:0] operand_s;

  // Saturating increment of the unknown-opcode counter.
  function automatic logic [BAD_CNT_W-1:0] sat_inc(input logic [BAD_CNT_W-1:0] v);
    logic [BAD_CNT_W-1:0] r;
    if (v == BAD_MAX) begin
      r = v;
    end else begin
      r = v + BAD_ONE;
    end
    return r;
  endfunction

  // A held execute level yields a single acceptance; exec_q clears in reset,
  // so execute already high at release is seen as an edge.
  assign accept_s  = execute & ~exec_q;
  assign op_s      = cmd[7:0];
  assign operand_s = cmd[39:8];

  // Next-state decode for the register file, pulses and handshakes.
  always_comb begin
    soft_reset_d     = 1'b0;
    trig_wr_mask_d   = 1'b0;
    trig_wr_value_d  = 1'b0;
    trig_wr_config_d = 1'b0;
    xoff_d           = xoff_q;
    divider_d        = divider_q;
    read_count_d     = read_count_q;
    delay_count_d    = delay_count_q;
    flags_d          = flags_q;
    trig_stage_d     = trig_stage_q;
    trig_data_d      = trig_data_q;
    bad_cnt_d        = bad_cnt_q;

    // Acknowledge clears first so that a coincident set or soft reset,
    // decoded below, takes priority.
    if (arm_ack) begin
      arm_req_d = 1'b0;
    end else begin
      arm_req_d = arm_req_q;
    end

    if (accept_s) begin
      case (op_s)
        OP_RESET: begin
          soft_reset_d = 1'b1;
          arm_req_d    = 1'b0;
          xoff_d       = 1'b0;
        end
        OP_ARM:     arm_req_d = 1'b1;
        OP_XON:     xoff_d    = 1'b0;
        OP_XOFF:    xoff_d    = 1'b1;
        OP_QUERY_ID, OP_QUERY_META, OP_QUERY_INPUT: begin
          // Answered by the SPI slave; nothing to do here.
          xoff_d = xoff_q;
        end
        OP_DIVIDER: divider_d = operand_s[23:0];
        OP_COUNTS: begin
          read_count_d  = operand_s[15:0];
          delay_count_d = operand_s[31:16];
        end
        OP_FLAGS:   flags_d = operand_s[15:0];
        default: begin
          if (is_trig_op(op_s)) begin
            case (op_s[1:0])
              TRIG_KIND_MASK: begin
                trig_wr_mask_d = 1'b1;
                trig_stage_d   = op_s[3:2];
                trig_data_d    = operand_s;
              end
              TRIG_KIND_VALUE: begin
                trig_wr_value_d = 1'b1;
                trig_stage_d    = op_s[3:2];
                trig_data_d     = operand_s;
              end
              TRIG_KIND_CONFIG: begin
                trig_wr_config_d = 1'b1;
                trig_stage_d     = op_s[3:2];
                trig_data_d      = operand_s;
              end
              // Kind 3 is reserved: counted as bad, stage/data untouched.
              default: bad_cnt_d = sat_inc(bad_cnt_q);
            endcase
          end else begin
            bad_cnt_d = sat_inc(bad_cnt_q);
          end
        end
      endcase
    end else begin
      bad_cnt_d = bad_cnt_q;
    end
  end

  // State and output registers; asynchronous reset clears everything.
  always_ff @(posedge clock or negedge extReset_n) begin
    if (!extReset_n) begin
      exec_q           <= 1'b0;
      soft_reset_q     <= 1'b0;
      arm_req_q        <= 1'b0;
      xoff_q           <= 1'b0;
      divider_q        <= 24'd0;
      read_count_q     <= 16'd0;
      delay_count_q    <= 16'd0;
      flags_q          <= 16'd0;
      trig_wr_mask_q   <= 1'b0;
      trig_wr_value_q  <= 1'b0;
      trig_wr_config_q <= 1'b0;
      trig_stage_q     <= 2'd0;
      trig_data_q      <= 32'd0;
      bad_cnt_q        <= {BAD_CNT_W{1'b0}};
    end else begin
      exec_q           <= execute;
      soft_reset_q     <= soft_reset_d;
      arm_req_q        <= arm_req_d;
      xoff_q           <= xoff_d;
      divider_q        <= divider_d;
      read_count_q     <= read_count_d;
      delay_count_q    <= delay_count_d;
      flags_q          <= flags_d;
      trig_wr_mask_q   <= trig_wr_mask_d;
      trig_wr_value_q  <= trig_wr_value_d;
      trig_wr_config_q <= trig_wr_config_d;
      trig_stage_q     <= trig_stage_d;
      trig_data_q      <= trig_data_d;
      bad_cnt_q        <= bad_cnt_d;
    end
  end

  assign soft_reset     = soft_reset_q;
  assign arm_req        = arm_req_q;
  assign xoff           = xoff_q;
  assign divider        = divider_q;
  assign read_count     = read_count_q;
  assign delay_count    = delay_count_q;
  assign flags          = flags_q;
  assign trig_wr_mask   = trig_wr_mask_q;
  assign trig_wr_value  = trig_wr_value_q;
  assign trig_wr_config = trig_wr_config_q;
  assign trig_stage     = trig_stage_q;
  assign trig_data      = trig_data_q;
  assign bad_cmd_count  = bad_cnt_q;

endmodule : sump_cmd_decoder
